// File: rtl/hash_writeback_pkg.sv
// Shared types and constants for the hash digest writeback stage.
package hash_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } hash_wb_state_t;

  localparam int SHA256_DIGEST_WIDTH = 256;
  localparam int SHA224_DIGEST_WIDTH = 224;
  localparam int HASH_WORD_WIDTH     = 32;

endpackage

// File: rtl/hash_writeback_if.sv
// Write port between the digest writeback stage and the hash output memory.
interface hash_wb_if
  import hash_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int WORD_WIDTH = HASH_WORD_WIDTH
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/hash_writeback_word_select.sv
// Picks one word of the digest by index in the configured order; the optional
// byte reversal is present only when HASH_WRITEBACK_BYTESWAP_EN is defined.
module hash_word_select
  import hash_pkg::*;
#(
  parameter int DIGEST_WIDTH = SHA256_DIGEST_WIDTH,
  parameter int WORD_WIDTH   = HASH_WORD_WIDTH,
  parameter bit MSW_FIRST    = 1'b1,
  localparam int NUM_WORDS   = DIGEST_WIDTH / WORD_WIDTH,
  localparam int CNT_WIDTH   = $clog2(NUM_WORDS + 1)
) (
  input  logic [DIGEST_WIDTH-1:0] data,
  input  logic [CNT_WIDTH-1:0]    idx,
`ifdef HASH_WRITEBACK_BYTESWAP_EN
  input  logic                    swap,
`endif
  output logic [WORD_WIDTH-1:0]   word
);

  logic [WORD_WIDTH-1:0] raw;

  // idx one past the end shows up on the final transfer; its result is never loaded
  always_comb begin
    int pos;
    pos = int'(idx);
    if (pos >= NUM_WORDS) pos = 0;
    if (MSW_FIRST) pos = NUM_WORDS - 1 - pos;
    raw = data[pos*WORD_WIDTH +: WORD_WIDTH];
  end

`ifdef HASH_WRITEBACK_BYTESWAP_EN
  always_comb begin
    word = raw;
    if (swap) begin
      for (int b = 0; b < WORD_WIDTH / 8; b++) begin
        word[b*8 +: 8] = raw[(WORD_WIDTH/8 - 1 - b)*8 +: 8];
      end
    end
  end
`else
  assign word = raw;
`endif

endmodule

// File: rtl/hash_writeback.sv
// Captures a digest on start and writes it word by word over a valid/ready port.
// Build option HASH_WRITEBACK_BYTESWAP_EN adds a per-job byte_swap input.
//
//   state | meaning
//   IDLE  | waiting for start
//   WRITE | presenting word[idx] until the sink accepts it
//   DONE  | one-cycle done pulse, start ignored
module hash_writeback
  import hash_pkg::*;
#(
  parameter int DIGEST_WIDTH = SHA256_DIGEST_WIDTH,
  parameter int WORD_WIDTH   = HASH_WORD_WIDTH,
  parameter int ADDR_WIDTH   = 3,
  parameter bit MSW_FIRST    = 1'b1,
  localparam int NUM_WORDS   = DIGEST_WIDTH / WORD_WIDTH,
  localparam int CNT_WIDTH   = $clog2(NUM_WORDS + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DIGEST_WIDTH-1:0] digest,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
`ifdef HASH_WRITEBACK_BYTESWAP_EN
  input  logic                    byte_swap,
`endif
  hash_wb_if.master               wr,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    words_written
);

  if ((DIGEST_WIDTH % WORD_WIDTH) != 0 || NUM_WORDS > (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("hash_writeback: DIGEST_WIDTH/WORD_WIDTH/ADDR_WIDTH combination is illegal");
  end
`ifdef HASH_WRITEBACK_BYTESWAP_EN
  if ((WORD_WIDTH % 8) != 0) begin : g_bad_swap
    $error("hash_writeback: byte swap needs WORD_WIDTH to be a multiple of 8");
  end
`endif

  hash_wb_state_t          state, state_next;
  logic [DIGEST_WIDTH-1:0] shadow;
  logic [CNT_WIDTH-1:0]    idx;
  logic [CNT_WIDTH-1:0]    sel_idx;
  logic [DIGEST_WIDTH-1:0] sel_src;
  logic [WORD_WIDTH-1:0]   sel_word;
  logic                    start_ok;
  logic                    xfer;
  logic                    last;

  assign start_ok      = (state == IDLE) && start;
  assign xfer          = wr.wr_valid && wr.wr_ready;
  assign last          = (idx == CNT_WIDTH'(NUM_WORDS - 1));
  assign wr.wr_valid   = (state == WRITE);
  assign busy          = (state == WRITE);
  assign done          = (state == DONE);
  assign words_written = idx;

  // In IDLE the selector looks at the live digest so word 0 is registered by the start edge
  assign sel_src = (state == IDLE) ? digest : shadow;
  assign sel_idx = (state == IDLE) ? '0 : idx + CNT_WIDTH'(1);

`ifdef HASH_WRITEBACK_BYTESWAP_EN
  logic swap_q;
  logic sel_swap;
  assign sel_swap = (state == IDLE) ? byte_swap : swap_q;
`endif

  hash_word_select #(
    .DIGEST_WIDTH (DIGEST_WIDTH),
    .WORD_WIDTH   (WORD_WIDTH),
    .MSW_FIRST    (MSW_FIRST)
  ) u_word_select (
    .data (sel_src),
    .idx  (sel_idx),
`ifdef HASH_WRITEBACK_BYTESWAP_EN
    .swap (sel_swap),
`endif
    .word (sel_word)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = WRITE;
      WRITE:   if (xfer && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow     <= '0;
      idx        <= '0;
      wr.wr_addr <= '0;
      wr.wr_data <= '0;
`ifdef HASH_WRITEBACK_BYTESWAP_EN
      swap_q     <= 1'b0;
`endif
    end else if (start_ok) begin
      shadow     <= digest;
      idx        <= '0;
      wr.wr_addr <= base_addr;
      wr.wr_data <= sel_word;
`ifdef HASH_WRITEBACK_BYTESWAP_EN
      swap_q     <= byte_swap;
`endif
    end else if (xfer) begin
      idx        <= idx + CNT_WIDTH'(1);
      wr.wr_addr <= wr.wr_addr + ADDR_WIDTH'(1);
      if (!last) wr.wr_data <= sel_word;
    end
  end

endmodule

// File: tb/tb_hash_writeback.sv
// Directed bench for hash_writeback: default, LSW-first and SHA-224 instances.
module tb_hash_writeback;
  import hash_pkg::*;

  localparam logic [255:0] ABC256 =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [223:0] ABC224 =
    224'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61;
  localparam logic [31:0] W [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  logic clock = 1'b0;
  logic reset;
  logic start0, start1, start2;
  logic ready0, ready1, ready2;
  logic bswap;
  logic [255:0] digest;
  logic [223:0] digest2;
  logic [2:0] base_addr, base2;
  logic busy0, done0, busy1, done1, busy2, done2;
  logic [3:0] ww0, ww1;
  logic [2:0] ww2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0;

  hash_wb_if #(.ADDR_WIDTH(3), .WORD_WIDTH(32)) if0 ();
  hash_wb_if #(.ADDR_WIDTH(3), .WORD_WIDTH(32)) if1 ();
  hash_wb_if #(.ADDR_WIDTH(3), .WORD_WIDTH(32)) if2 ();
  assign if0.wr_ready = ready0;
  assign if1.wr_ready = ready1;
  assign if2.wr_ready = ready2;

  hash_writeback dut0 (
    .clock(clock), .reset(reset), .start(start0), .digest(digest), .base_addr(base_addr),
`ifdef HASH_WRITEBACK_BYTESWAP_EN
    .byte_swap(bswap),
`endif
    .wr(if0), .busy(busy0), .done(done0), .words_written(ww0));

  hash_writeback #(.MSW_FIRST(1'b0)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .digest(digest), .base_addr(base_addr),
`ifdef HASH_WRITEBACK_BYTESWAP_EN
    .byte_swap(1'b0),
`endif
    .wr(if1), .busy(busy1), .done(done1), .words_written(ww1));

  hash_writeback #(.DIGEST_WIDTH(SHA224_DIGEST_WIDTH)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .digest(digest2), .base_addr(base2),
`ifdef HASH_WRITEBACK_BYTESWAP_EN
    .byte_swap(1'b0),
`endif
    .wr(if2), .busy(busy2), .done(done2), .words_written(ww2));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Sink-side logs, sampled on the falling edge
  int          q0_cyc[$], q1_cyc[$], q2_cyc[$];
  logic [2:0]  q0_addr[$], q1_addr[$], q2_addr[$];
  logic [31:0] q0_data[$], q1_data[$], q2_data[$];
  int          d0_cyc[$], d1_cyc[$], d2_cyc[$];
  logic        stall_prev = 1'b0;
  logic [2:0]  stall_addr;
  logic [31:0] stall_data;
  int          stall_viol = 0;

  always @(negedge clock) begin
    if (stall_prev && (if0.wr_valid !== 1'b1 || if0.wr_addr !== stall_addr ||
                       if0.wr_data !== stall_data)) stall_viol++;
    stall_prev = if0.wr_valid && !ready0 && !reset;
    stall_addr = if0.wr_addr;
    stall_data = if0.wr_data;
    if (if0.wr_valid && ready0 && !reset) begin
      q0_cyc.push_back(cyc); q0_addr.push_back(if0.wr_addr); q0_data.push_back(if0.wr_data);
    end
    if (if1.wr_valid && ready1 && !reset) begin
      q1_cyc.push_back(cyc); q1_addr.push_back(if1.wr_addr); q1_data.push_back(if1.wr_data);
    end
    if (if2.wr_valid && ready2 && !reset) begin
      q2_cyc.push_back(cyc); q2_addr.push_back(if2.wr_addr); q2_data.push_back(if2.wr_data);
    end
    if (done0) d0_cyc.push_back(cyc);
    if (done1) d1_cyc.push_back(cyc);
    if (done2) d2_cyc.push_back(cyc);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    q0_cyc.delete(); q0_addr.delete(); q0_data.delete(); d0_cyc.delete();
    q1_cyc.delete(); q1_addr.delete(); q1_data.delete(); d1_cyc.delete();
    q2_cyc.delete(); q2_addr.delete(); q2_data.delete(); d2_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({if0.wr_valid, busy0, done0, ww0, if0.wr_addr, if0.wr_data} !== 41'd0) begin
      failures++;
      $display("FAIL reset_dut0 got valid=%b busy=%b done=%b ww=%0d addr=%0d data=%h want all zero",
               if0.wr_valid, busy0, done0, ww0, if0.wr_addr, if0.wr_data);
    end
    checks++;
    if ({if1.wr_valid, busy1, done1, ww1, if1.wr_addr, if1.wr_data} !== 41'd0) begin
      failures++;
      $display("FAIL reset_dut1 got valid=%b busy=%b done=%b ww=%0d want all zero",
               if1.wr_valid, busy1, done1, ww1);
    end
    checks++;
    if ({if2.wr_valid, busy2, done2, ww2, if2.wr_addr, if2.wr_data} !== 40'd0) begin
      failures++;
      $display("FAIL reset_dut2 got valid=%b busy=%b done=%b ww=%0d want all zero",
               if2.wr_valid, busy2, done2, ww2);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_order();
    clear_logs();
    step();
    t0 = cyc; digest = ABC256; base_addr = 3'd0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || if0.wr_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got busy=%b valid=%b want 1 1", busy0, if0.wr_valid);
    end
    repeat (12) step();
    checks++;
    if (q0_cyc.size() != 8) begin
      failures++;
      $display("FAIL basic_count got %0d writes want 8", q0_cyc.size());
    end
    for (int i = 0; i < 8 && i < q0_cyc.size(); i++) begin
      checks++;
      if (q0_addr[i] !== 3'(i) || q0_data[i] !== W[i] || q0_cyc[i] - t0 != i + 1) begin
        failures++;
        $display("FAIL basic_word%0d got addr=%0d data=%h cycle=%0d want addr=%0d data=%h cycle=%0d",
                 i, q0_addr[i], q0_data[i], q0_cyc[i] - t0, i, W[i], i + 1);
      end
    end
    checks++;
    if (d0_cyc.size() != 1 || (d0_cyc.size() > 0 && d0_cyc[0] - t0 != 9)) begin
      failures++;
      $display("FAIL basic_done got %0d pulses first at %0d want 1 pulse at 9",
               d0_cyc.size(), d0_cyc.size() > 0 ? d0_cyc[0] - t0 : -1);
    end
    checks++;
    if (ww0 !== 4'd8) begin
      failures++;
      $display("FAIL basic_words_written got %0d want 8", ww0);
    end
  endtask

  task automatic test_reverse_order();
    clear_logs();
    step();
    t0 = cyc; digest = ABC256; base_addr = 3'd0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    repeat (12) step();
    checks++;
    if (q1_cyc.size() != 8) begin
      failures++;
      $display("FAIL reverse_count got %0d writes want 8", q1_cyc.size());
    end
    for (int i = 0; i < 8 && i < q1_cyc.size(); i++) begin
      checks++;
      if (q1_addr[i] !== 3'(i) || q1_data[i] !== W[7-i]) begin
        failures++;
        $display("FAIL reverse_word%0d got addr=%0d data=%h want addr=%0d data=%h",
                 i, q1_addr[i], q1_data[i], i, W[7-i]);
      end
    end
    checks++;
    if (d1_cyc.size() != 1 || ww1 !== 4'd8) begin
      failures++;
      $display("FAIL reverse_done got pulses=%0d ww=%0d want 1 and 8", d1_cyc.size(), ww1);
    end
  endtask

  task automatic test_backpressure();
    int exp_cyc [8] = '{1, 5, 6, 8, 9, 10, 11, 12};
    int viol0;
    clear_logs();
    viol0 = stall_viol;
    step();
    t0 = cyc; digest = ABC256; base_addr = 3'd0; start0 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      start0 = 1'b0;
      ready0 = !(c inside {2, 3, 4, 7});
      if (c == 3) begin
        checks++;
        if (if0.wr_valid !== 1'b1 || if0.wr_addr !== 3'd1 || if0.wr_data !== W[1]) begin
          failures++;
          $display("FAIL bp_stall_word got valid=%b addr=%0d data=%h want 1 1 %h",
                   if0.wr_valid, if0.wr_addr, if0.wr_data, W[1]);
        end
      end
    end
    ready0 = 1'b1;
    checks++;
    if (q0_cyc.size() != 8) begin
      failures++;
      $display("FAIL bp_count got %0d writes want 8", q0_cyc.size());
    end
    for (int i = 0; i < 8 && i < q0_cyc.size(); i++) begin
      checks++;
      if (q0_addr[i] !== 3'(i) || q0_data[i] !== W[i] || q0_cyc[i] - t0 != exp_cyc[i]) begin
        failures++;
        $display("FAIL bp_word%0d got addr=%0d data=%h cycle=%0d want addr=%0d data=%h cycle=%0d",
                 i, q0_addr[i], q0_data[i], q0_cyc[i] - t0, i, W[i], exp_cyc[i]);
      end
    end
    checks++;
    if (d0_cyc.size() != 1 || (d0_cyc.size() > 0 && d0_cyc[0] - t0 != 13)) begin
      failures++;
      $display("FAIL bp_done got %0d pulses first at %0d want 1 pulse at 13",
               d0_cyc.size(), d0_cyc.size() > 0 ? d0_cyc[0] - t0 : -1);
    end
    checks++;
    if (stall_viol != viol0) begin
      failures++;
      $display("FAIL bp_stable got %0d unstable stall cycles want 0", stall_viol - viol0);
    end
  endtask

  task automatic test_wrap_sha224();
    logic [2:0] exp_addr [7] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    clear_logs();
    step();
    t0 = cyc; digest2 = ABC224; base2 = 3'd5; start2 = 1'b1;
    step();
    start2 = 1'b0;
    repeat (10) step();
    checks++;
    if (q2_cyc.size() != 7) begin
      failures++;
      $display("FAIL wrap_count got %0d writes want 7", q2_cyc.size());
    end
    for (int i = 0; i < 7 && i < q2_cyc.size(); i++) begin
      checks++;
      if (q2_addr[i] !== exp_addr[i] || q2_data[i] !== W[i]) begin
        failures++;
        $display("FAIL wrap_word%0d got addr=%0d data=%h want addr=%0d data=%h",
                 i, q2_addr[i], q2_data[i], exp_addr[i], W[i]);
      end
    end
    checks++;
    if (d2_cyc.size() != 1 || (d2_cyc.size() > 0 && d2_cyc[0] - t0 != 8) || ww2 !== 3'd7) begin
      failures++;
      $display("FAIL wrap_done got pulses=%0d ww=%0d want 1 pulse at 8 and ww=7",
               d2_cyc.size(), ww2);
    end
  endtask

  task automatic test_start_corners();
    clear_logs();
    step();
    t0 = cyc; digest = ABC256; base_addr = 3'd0; start0 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      start0 = (c == 3 || c == 9);
      if (c == 1) begin
        digest = {8{32'h55aa55aa}};
        base_addr = 3'd3;
      end
      if (c == 10) begin
        checks++;
        if (busy0 !== 1'b0 || if0.wr_valid !== 1'b0) begin
          failures++;
          $display("FAIL corner_start_at_done got busy=%b valid=%b want 0 0", busy0, if0.wr_valid);
        end
      end
    end
    start0 = 1'b0;
    digest = ABC256;
    base_addr = 3'd0;
    checks++;
    if (q0_cyc.size() != 8) begin
      failures++;
      $display("FAIL corner_count got %0d writes want 8", q0_cyc.size());
    end
    for (int i = 0; i < 8 && i < q0_cyc.size(); i++) begin
      checks++;
      if (q0_addr[i] !== 3'(i) || q0_data[i] !== W[i]) begin
        failures++;
        $display("FAIL corner_word%0d got addr=%0d data=%h want addr=%0d data=%h",
                 i, q0_addr[i], q0_data[i], i, W[i]);
      end
    end
    checks++;
    if (d0_cyc.size() != 1) begin
      failures++;
      $display("FAIL corner_done got %0d pulses want 1", d0_cyc.size());
    end
  endtask

  task automatic test_reset_mid_job();
    clear_logs();
    step();
    t0 = cyc; digest = ABC256; base_addr = 3'd0; start0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start0 = 1'b0;
      if (c == 4) begin
        reset = 1'b1;
        ready0 = 1'b0;
      end
      if (c == 5) begin
        reset = 1'b0;
        ready0 = 1'b1;
        checks++;
        if ({if0.wr_valid, busy0, done0, ww0, if0.wr_addr, if0.wr_data} !== 41'd0) begin
          failures++;
          $display("FAIL midreset_outputs got valid=%b busy=%b done=%b ww=%0d addr=%0d data=%h want all zero",
                   if0.wr_valid, busy0, done0, ww0, if0.wr_addr, if0.wr_data);
        end
      end
    end
    checks++;
    if (q0_cyc.size() != 3 || d0_cyc.size() != 0) begin
      failures++;
      $display("FAIL midreset_abandon got writes=%0d done=%0d want 3 and 0",
               q0_cyc.size(), d0_cyc.size());
    end
    clear_logs();
    step();
    t0 = cyc; base_addr = 3'd2; start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (12) step();
    checks++;
    if (q0_cyc.size() != 8) begin
      failures++;
      $display("FAIL restart_count got %0d writes want 8", q0_cyc.size());
    end
    for (int i = 0; i < 8 && i < q0_cyc.size(); i++) begin
      checks++;
      if (q0_addr[i] !== 3'(i + 2) || q0_data[i] !== W[i]) begin
        failures++;
        $display("FAIL restart_word%0d got addr=%0d data=%h want addr=%0d data=%h",
                 i, q0_addr[i], q0_data[i], (i + 2) % 8, W[i]);
      end
    end
    checks++;
    if (d0_cyc.size() != 1 || (d0_cyc.size() > 0 && d0_cyc[0] - t0 != 9) || ww0 !== 4'd8) begin
      failures++;
      $display("FAIL restart_done got pulses=%0d ww=%0d want 1 pulse at 9 and ww=8",
               d0_cyc.size(), ww0);
    end
    base_addr = 3'd0;
  endtask

`ifdef HASH_WRITEBACK_BYTESWAP_EN
  task automatic test_byte_swap();
    clear_logs();
    step();
    t0 = cyc; digest = ABC256; base_addr = 3'd0; bswap = 1'b1; start0 = 1'b1;
    step();
    start0 = 1'b0;
    bswap = 1'b0;
    checks++;
    if (if0.wr_data !== 32'hbf1678ba) begin
      failures++;
      $display("FAIL swap_first got %h want bf1678ba", if0.wr_data);
    end
    repeat (12) step();
    checks++;
    if (q0_cyc.size() != 8 || (q0_cyc.size() == 8 && q0_data[7] !== 32'had1500f2)) begin
      failures++;
      $display("FAIL swap_last got writes=%0d last=%h want 8 and ad1500f2",
               q0_cyc.size(), q0_cyc.size() > 0 ? q0_data[q0_cyc.size()-1] : 32'h0);
    end
  endtask
`endif

  initial begin
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
    bswap = 1'b0;
    digest = ABC256; digest2 = ABC224;
    base_addr = 3'd0; base2 = 3'd0;
    test_reset();
    test_basic_order();
    test_reverse_order();
    test_backpressure();
    test_wrap_sha224();
    test_start_corners();
    test_reset_mid_job();
`ifdef HASH_WRITEBACK_BYTESWAP_EN
    test_byte_swap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
